pattern_det_ctrl: RTL

PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

---
 rtl/pattern_det_pkg.sv | 10 +
 rtl/pattern_det_ctrl_if.sv | 23 ++
 rtl/pattern_det_cmp.sv | 25 ++
 rtl/pattern_det_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding.
package pattern_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_det_ctrl_if.sv
// Configuration handshake bundle: pattern, length, overlap mode and scan window.
interface pattern_det_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned WIN_W   = 8,
  parameter int unsigned LEN_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
    output cfg_ready
  );
endinterface

// File: rtl/pattern_det_cmp.sv
// Masked compare of {history, din} against the pattern over the low len+1 bits.
module pattern_det_cmp #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic [MAX_LEN-2:0] hist_i,
  input  logic               din_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    cand = {hist_i, din_i};
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i <= int'(len_i));
    end
    hit_o = (((cand ^ pattern_i) & mask) == '0);
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Serial pattern detector: config latch, IDLE/RUN/DONE scan FSM, match/fill/window counters.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pattern_det_ctrl_if.slave   cfg,
  input  logic                start,
  input  logic                stop,
  input  logic                din,
  input  logic                din_valid,
  output logic                dout,
  output logic [CNT_W-1:0]    match_count,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);
  localparam int unsigned HIST_W = MAX_LEN - 1;

  state_e              state_q, state_d;
  logic [HIST_W-1:0]   hist_q,  hist_d;
  logic [FILL_W-1:0]   fill_q,  fill_d;
  logic [WIN_W-1:0]    scan_q,  scan_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [MAX_LEN-1:0]  pat_q,   pat_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic                ov_q,    ov_d;
  logic [WIN_W-1:0]    win_q,   win_d;
  logic                hit;
  logic                cfg_hs;

  pattern_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist_i    (hist_q),
    .din_i     (din),
    .pattern_i (pat_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  assign cfg.cfg_ready = (state_q != ST_RUN);
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign match_count   = cnt_q;
  assign cfg_hs        = cfg.cfg_valid && (state_q != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      scan_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ov_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    scan_d  = scan_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ov_d    = ov_q;
    win_d   = win_q;
    dout    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A config handshake takes priority and swallows a same-cycle start.
        if (cfg_hs) begin
          pat_d   = cfg.cfg_pattern;
          len_d   = cfg.cfg_len;
          ov_d    = cfg.cfg_overlap;
          win_d   = cfg.cfg_window;
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          hist_d  = '0;
          fill_d  = '0;
          scan_d  = '0;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (din_valid) begin
          dout   = (fill_q >= FILL_W'(len_q)) && hit;
          hist_d = HIST_W'({hist_q, din});
          scan_d = scan_q + WIN_W'(1);
          // Non-overlapping mode restarts the fill so matched bits are not reused.
          if (dout && !ov_q) begin
            fill_d = '0;
          end else if (fill_q != FILL_W'(MAX_LEN)) begin
            fill_d = fill_q + FILL_W'(1);
          end
          if (dout && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if ((win_q != '0) && (scan_q == win_q - WIN_W'(1))) begin
            state_d = ST_DONE;
          end
        end
        if (stop) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
